// File: rtl/mm_arb_pkg.sv
// Shared types and defaults for the two-requester matrix-multiply arbiter.
package mm_arb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_FEED,
      ST_DRAIN,
      ST_FIN
   } state_e;

   localparam int DEF_IN_WORDS  = 32;
   localparam int DEF_OUT_WORDS = 16;

   function automatic int max_words(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/mm_arb_rr.sv
// Two-way round-robin picker: on contention the requester not served last wins.
module mm_arb_rr
   import mm_arb_pkg::*;
(
   input  logic [1:0] pending,
   input  logic       last,
   output logic [1:0] grant
);

   always_comb begin
      grant = pending;
      if (pending == 2'b11) begin
         grant = last ? 2'b01 : 2'b10;
      end
   end

endmodule

// File: rtl/mm_arb.sv
// Shares one mm engine between two requesters; one whole job (feed A/B,
// drain result, wait for done) is owned by a single requester at a time.
module mm_arb
   import mm_arb_pkg::*;
#(
   parameter int pDATA_WIDTH = 32,
   parameter int pIN_WORDS   = DEF_IN_WORDS,
   parameter int pOUT_WORDS  = DEF_OUT_WORDS
) (
   input  logic                   axis_clk,
   input  logic                   axis_rst_n,
   input  logic [1:0]             req_start,
   output logic [1:0]             req_grant,
   output logic [1:0]             req_done,
   input  logic                   r0_ss_tvalid,
   input  logic [pDATA_WIDTH-1:0] r0_ss_tdata,
   output logic                   r0_ss_tready,
   input  logic                   r1_ss_tvalid,
   input  logic [pDATA_WIDTH-1:0] r1_ss_tdata,
   output logic                   r1_ss_tready,
   output logic                   r0_sm_tvalid,
   output logic [pDATA_WIDTH-1:0] r0_sm_tdata,
   input  logic                   r0_sm_tready,
   output logic                   r1_sm_tvalid,
   output logic [pDATA_WIDTH-1:0] r1_sm_tdata,
   input  logic                   r1_sm_tready,
   output logic                   mm_start,
   input  logic                   mm_done,
   input  logic                   mm_idle,
   output logic                   mm_ss_tvalid,
   output logic [pDATA_WIDTH-1:0] mm_ss_tdata,
   input  logic                   mm_ss_tready,
   input  logic                   mm_sm_tvalid,
   input  logic [pDATA_WIDTH-1:0] mm_sm_tdata,
   output logic                   mm_sm_tready
);

   localparam int CW = $clog2(max_words(pIN_WORDS, pOUT_WORDS) + 1);
   localparam logic [CW-1:0] IN_LAST  = CW'(pIN_WORDS - 1);
   localparam logic [CW-1:0] OUT_LAST = CW'(pOUT_WORDS - 1);

   state_e        state_q, state_d;
   logic [1:0]    pend_q, pend_d;
   logic [1:0]    grant_q, grant_d;
   logic [1:0]    done_q, done_d;
   logic          start_q, start_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          seen_q, seen_d;
   logic          last_q, last_d;

   logic [1:0] rr_gnt;
   logic       feed, drain, sel;
   logic       ss_beat, sm_beat;

   mm_arb_rr u_rr (
      .pending (pend_q),
      .last    (last_q),
      .grant   (rr_gnt)
   );

   assign feed  = (state_q == ST_FEED);
   assign drain = (state_q == ST_DRAIN);
   assign sel   = grant_q[1];

   // Pure muxing on the owned grant: no extra latency on either stream.
   assign mm_ss_tvalid = feed & (sel ? r1_ss_tvalid : r0_ss_tvalid);
   assign mm_ss_tdata  = sel ? r1_ss_tdata : r0_ss_tdata;
   assign r0_ss_tready = feed & grant_q[0] & mm_ss_tready;
   assign r1_ss_tready = feed & grant_q[1] & mm_ss_tready;

   assign mm_sm_tready = drain & (sel ? r1_sm_tready : r0_sm_tready);
   assign r0_sm_tvalid = drain & grant_q[0] & mm_sm_tvalid;
   assign r1_sm_tvalid = drain & grant_q[1] & mm_sm_tvalid;
   assign r0_sm_tdata  = mm_sm_tdata;
   assign r1_sm_tdata  = mm_sm_tdata;

   assign ss_beat = mm_ss_tvalid & mm_ss_tready;
   assign sm_beat = mm_sm_tvalid & mm_sm_tready;

   assign req_grant = grant_q;
   assign req_done  = done_q;
   assign mm_start  = start_q;

   always_comb begin
      state_d = state_q;
      pend_d  = pend_q | req_start;
      grant_d = grant_q;
      done_d  = 2'b00;
      start_d = 1'b0;
      cnt_d   = cnt_q;
      seen_d  = seen_q;
      last_d  = last_q;
      if (state_q != ST_IDLE && mm_done) begin
         seen_d = 1'b1;
      end
      unique case (state_q)
         ST_IDLE: begin
            if (|pend_q && mm_idle) begin
               grant_d = rr_gnt;
               pend_d  = (pend_q & ~rr_gnt) | req_start;
               last_d  = rr_gnt[1];
               start_d = 1'b1;
               state_d = ST_START;
            end
         end
         ST_START: begin
            cnt_d   = '0;
            state_d = ST_FEED;
         end
         ST_FEED: begin
            if (ss_beat) begin
               if (cnt_q == IN_LAST) begin
                  cnt_d   = '0;
                  state_d = ST_DRAIN;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         ST_DRAIN: begin
            if (sm_beat) begin
               if (cnt_q == OUT_LAST) begin
                  cnt_d   = '0;
                  state_d = ST_FIN;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         ST_FIN: begin
            if (seen_q | mm_done) begin
               done_d  = grant_q;
               grant_d = 2'b00;
               seen_d  = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge axis_clk or negedge axis_rst_n) begin
      if (!axis_rst_n) begin
         state_q <= ST_IDLE;
         pend_q  <= 2'b00;
         grant_q <= 2'b00;
         done_q  <= 2'b00;
         start_q <= 1'b0;
         cnt_q   <= '0;
         seen_q  <= 1'b0;
         last_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         grant_q <= grant_d;
         done_q  <= done_d;
         start_q <= start_d;
         cnt_q   <= cnt_d;
         seen_q  <= seen_d;
         last_q  <= last_d;
      end
   end

endmodule

// File: tb/tb_mm_arb.sv
// Directed job-level bench for mm_arb: a small mm engine and requester
// model run each table row as one job and check counts, order and pulses.
module tb_mm_arb;

   localparam int DW   = 32;
   localparam int NIN  = 32;
   localparam int NOUT = 16;

   logic          axis_clk = 1'b0;
   logic          axis_rst_n = 1'b0;
   logic [1:0]    req_start;
   logic [1:0]    req_grant, req_done;
   logic          r0_ss_tvalid, r0_ss_tready, r1_ss_tvalid, r1_ss_tready;
   logic [DW-1:0] r0_ss_tdata, r1_ss_tdata;
   logic          r0_sm_tvalid, r0_sm_tready, r1_sm_tvalid, r1_sm_tready;
   logic [DW-1:0] r0_sm_tdata, r1_sm_tdata;
   logic          mm_start, mm_done, mm_idle;
   logic          mm_ss_tvalid, mm_ss_tready, mm_sm_tvalid, mm_sm_tready;
   logic [DW-1:0] mm_ss_tdata, mm_sm_tdata;

   always #5 axis_clk = ~axis_clk;

   mm_arb #(.pDATA_WIDTH(DW), .pIN_WORDS(NIN), .pOUT_WORDS(NOUT)) dut (
      .axis_clk     (axis_clk),
      .axis_rst_n   (axis_rst_n),
      .req_start    (req_start),
      .req_grant    (req_grant),
      .req_done     (req_done),
      .r0_ss_tvalid (r0_ss_tvalid),
      .r0_ss_tdata  (r0_ss_tdata),
      .r0_ss_tready (r0_ss_tready),
      .r1_ss_tvalid (r1_ss_tvalid),
      .r1_ss_tdata  (r1_ss_tdata),
      .r1_ss_tready (r1_ss_tready),
      .r0_sm_tvalid (r0_sm_tvalid),
      .r0_sm_tdata  (r0_sm_tdata),
      .r0_sm_tready (r0_sm_tready),
      .r1_sm_tvalid (r1_sm_tvalid),
      .r1_sm_tdata  (r1_sm_tdata),
      .r1_sm_tready (r1_sm_tready),
      .mm_start     (mm_start),
      .mm_done      (mm_done),
      .mm_idle      (mm_idle),
      .mm_ss_tvalid (mm_ss_tvalid),
      .mm_ss_tdata  (mm_ss_tdata),
      .mm_ss_tready (mm_ss_tready),
      .mm_sm_tvalid (mm_sm_tvalid),
      .mm_sm_tdata  (mm_sm_tdata),
      .mm_sm_tready (mm_sm_tready)
   );

   typedef struct {
      int         g;
      logic [1:0] pulse;
      bit         rnd;
      int         done_at;
      int         idle_dly;
      int         exp_start;
      int         abort_at;
      bit         repulse;
   } vec_t;

   vec_t tbl[11];
   int   checks = 0;
   int   failures = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge axis_clk);
      #1;
   endtask

   task automatic quiet_inputs();
      req_start    = 2'b00;
      r0_ss_tvalid = 1'b0;
      r1_ss_tvalid = 1'b0;
      r0_ss_tdata  = '0;
      r1_ss_tdata  = '0;
      r0_sm_tready = 1'b0;
      r1_sm_tready = 1'b0;
      mm_done      = 1'b0;
      mm_idle      = 1'b1;
      mm_ss_tready = 1'b0;
      mm_sm_tvalid = 1'b0;
      mm_sm_tdata  = '0;
   endtask

   function automatic int out_vec();
      return int'({req_grant, req_done, mm_start, mm_ss_tvalid,
                   mm_sm_tready, r0_ss_tready, r1_ss_tready,
                   r0_sm_tvalid, r1_sm_tvalid});
   endfunction

   task automatic run_job(input vec_t v, input int idx);
      int         starts, st_cyc, mm_rx, mm_tx, rq_sent, rq_rx;
      int         ord, leak, stray, rx_done;
      logic [1:0] gnt_st, dval, gnt_done;
      bit         dpulsed, busy, aborted, rp;
      logic       gv, gr;
      logic       own_ss_v, own_ss_r, own_sm_v, own_sm_r;
      logic       oth_ss_r, oth_sm_v;
      logic [DW-1:0] sdat, own_sm_d;
      starts = 0; st_cyc = -1; mm_rx = 0; mm_tx = 0; rq_sent = 0;
      rq_rx = 0; ord = 0; leak = 0; stray = 0; rx_done = -1;
      gnt_st = 2'b00; dval = 2'b00; gnt_done = 2'b11;
      dpulsed = 0; busy = 0; aborted = 0; rp = 0;
      for (int c = 0; c < 600; c++) begin
         req_start = (c == 0) ? v.pulse : 2'b00;
         if (v.repulse && !rp && mm_rx == 3) begin
            req_start[v.g] = 1'b1;
            rp = 1;
         end
         gv   = (rq_sent < NIN) && (!v.rnd || $urandom_range(0, 1) == 1);
         gr   = !v.rnd || $urandom_range(0, 1) == 1;
         sdat = {8'(v.g + 1), 24'(rq_sent)};
         if (v.g == 0) begin
            r0_ss_tvalid = gv;   r0_ss_tdata = sdat;  r0_sm_tready = gr;
            r1_ss_tvalid = 1'b1; r1_ss_tdata = 32'hDEAD; r1_sm_tready = 1'b1;
         end else begin
            r1_ss_tvalid = gv;   r1_ss_tdata = sdat;  r1_sm_tready = gr;
            r0_ss_tvalid = 1'b1; r0_ss_tdata = 32'hDEAD; r0_sm_tready = 1'b1;
         end
         mm_ss_tready = !v.rnd || $urandom_range(0, 1) == 1;
         mm_sm_tvalid = (mm_rx == NIN) && (mm_tx < NOUT);
         mm_sm_tdata  = {8'hA0, 24'(mm_tx)};
         mm_done = !dpulsed && (mm_rx == NIN) &&
                   ((v.done_at >= 0) ? (mm_tx == v.done_at) : (mm_tx == NOUT));
         mm_idle = (c < v.idle_dly) ? 1'b0 : !busy;
         if (v.abort_at >= 0 && mm_rx == v.abort_at) axis_rst_n = 1'b0;
         #1;
         if (!axis_rst_n) begin
            aborted = 1;
            break;
         end
         own_ss_v = v.g ? r1_ss_tvalid : r0_ss_tvalid;
         own_ss_r = v.g ? r1_ss_tready : r0_ss_tready;
         own_sm_v = v.g ? r1_sm_tvalid : r0_sm_tvalid;
         own_sm_r = v.g ? r1_sm_tready : r0_sm_tready;
         own_sm_d = v.g ? r1_sm_tdata  : r0_sm_tdata;
         oth_ss_r = v.g ? r0_ss_tready : r1_ss_tready;
         oth_sm_v = v.g ? r0_sm_tvalid : r1_sm_tvalid;
         if (c == 0 && req_done != 2'b00) stray++;
         if (starts == 0 && !mm_start && req_grant != 2'b00) stray++;
         if (mm_start) begin
            starts++; st_cyc = c; gnt_st = req_grant; busy = 1;
         end
         if (mm_ss_tvalid && mm_ss_tready) begin
            if (mm_ss_tdata !== {8'(v.g + 1), 24'(mm_rx)}) ord++;
            mm_rx++;
         end
         if (own_ss_v && own_ss_r) rq_sent++;
         if (oth_ss_r || oth_sm_v) leak++;
         if (mm_sm_tvalid && mm_sm_tready) mm_tx++;
         if (own_sm_v && own_sm_r) begin
            if (own_sm_d !== {8'hA0, 24'(rq_rx)}) ord++;
            rq_rx++;
         end
         if (mm_done) begin
            dpulsed = 1; busy = 0;
         end
         if (req_done != 2'b00) begin
            dval = req_done; gnt_done = req_grant; rx_done = rq_rx;
            break;
         end
         step();
      end
      if (v.abort_at >= 0) begin
         chk($sformatf("v%0d_abort_reached", idx), int'(aborted), 1);
         chk($sformatf("v%0d_abort_outs", idx), out_vec(), 0);
         step();
         chk($sformatf("v%0d_reset_hold_outs", idx), out_vec(), 0);
         quiet_inputs();
         axis_rst_n = 1'b1;
         step();
         chk($sformatf("v%0d_post_reset_outs", idx), out_vec(), 0);
      end else begin
         chk($sformatf("v%0d_starts", idx), starts, 1);
         chk($sformatf("v%0d_start_cycle", idx), st_cyc, v.exp_start);
         chk($sformatf("v%0d_grant_at_start", idx), int'(gnt_st), 1 << v.g);
         chk($sformatf("v%0d_mm_in_beats", idx), mm_rx, NIN);
         chk($sformatf("v%0d_req_out_beats", idx), rq_rx, NOUT);
         chk($sformatf("v%0d_order_errs", idx), ord, 0);
         chk($sformatf("v%0d_other_leak", idx), leak, 0);
         chk($sformatf("v%0d_req_done", idx), int'(dval), 1 << v.g);
         chk($sformatf("v%0d_grant_at_done", idx), int'(gnt_done), 0);
         chk($sformatf("v%0d_beats_at_done", idx), rx_done, NOUT);
         chk($sformatf("v%0d_stray", idx), stray, 0);
         step();
      end
   endtask

   initial begin
      //          g  pulse  rnd done idle start abort repulse
      tbl[0]  = '{0, 2'b11, 0, -1, 0, 2, -1, 0};
      tbl[1]  = '{1, 2'b00, 0, -1, 0, 0, -1, 0};
      tbl[2]  = '{0, 2'b01, 0, -1, 0, 2, -1, 0};
      tbl[3]  = '{1, 2'b10, 1, -1, 0, 2, -1, 0};
      tbl[4]  = '{0, 2'b01, 0,  5, 0, 2, -1, 0};
      tbl[5]  = '{0, 2'b01, 0, -1, 5, 6, -1, 0};
      tbl[6]  = '{0, 2'b01, 0, -1, 0, 2, 10, 0};
      tbl[7]  = '{1, 2'b10, 0, -1, 0, 2, -1, 1};
      tbl[8]  = '{1, 2'b00, 0, -1, 0, 0, -1, 0};
      tbl[9]  = '{0, 2'b11, 0, -1, 0, 2, -1, 0};
      tbl[10] = '{1, 2'b00, 0, -1, 0, 0, -1, 0};

      quiet_inputs();
      req_start    = 2'b11;
      r0_ss_tvalid = 1'b1;
      r1_ss_tvalid = 1'b1;
      mm_ss_tready = 1'b1;
      mm_sm_tvalid = 1'b1;
      r0_sm_tready = 1'b1;
      r1_sm_tready = 1'b1;
      mm_done      = 1'b1;
      axis_rst_n   = 1'b0;
      step();
      step();
      chk("reset_outs", out_vec(), 0);
      quiet_inputs();
      axis_rst_n = 1'b1;
      step();
      step();
      chk("idle_no_pending_outs", out_vec(), 0);

      for (int i = 0; i < 11; i++) begin
         run_job(tbl[i], i);
      end

      quiet_inputs();
      step();
      chk("final_quiet_outs", out_vec(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mm_arb.md
MM_ARB -- requirements
Module: mm_arb

Interface
REQ-001 SHALL have parameter pDATA_WIDTH, default 32: stream data width.
REQ-002 SHALL have parameter pIN_WORDS, default 32: input words per job (A then B, 4x4 each).
REQ-003 SHALL have parameter pOUT_WORDS, default 16: result words per job.
REQ-004 SHALL have ports as follows, with one clock; reset is asynchronous and active-low:
- axis_clk  in  1  clock
- axis_rst_n  in  1  asynchronous active-low reset
- req_start  in  2  per-requester job request pulse
- req_grant  out  2  one-hot, owner of mm
- req_done  out  2  one-cycle job-complete pulse
- rN_ss_tvalid/rN_ss_tdata/rN_ss_tready  in/in/out  1/pDATA_WIDTH/1  requester N input stream (N=0,1)
- rN_sm_tvalid/rN_sm_tdata/rN_sm_tready  out/out/in  1/pDATA_WIDTH/1  requester N result stream
- mm_start  out  1  start pulse to mm
- mm_done, mm_idle  in  1 each  mm status
- mm_ss_tvalid/mm_ss_tdata/mm_ss_tready  out/out/in  1/pDATA_WIDTH/1  input stream to mm
- mm_sm_tvalid/mm_sm_tdata/mm_sm_tready  in/in/out  1/pDATA_WIDTH/1  result stream from mm

Function
REQ-005 SHALL latch each req_start[i] pulse into sticky pending[i]; pending[i] clears on the cycle req_grant[i] rises.
REQ-006 SHALL implement the FSM IDLE -> START -> FEED -> DRAIN -> FIN -> IDLE.
REQ-007 IDLE: when any pending bit is set and mm_idle=1, SHALL grant one requester and go to START next cycle; while mm_idle=0, SHALL stay in IDLE.
REQ-008 Arbitration SHALL be round-robin: if both are pending, grant the requester not served last; last-served resets to 1, so requester 0 wins first.
REQ-009 START: SHALL assert mm_start for exactly one cycle, clear the word counter, go to FEED.
REQ-010 FEED: mm_ss_tvalid SHALL equal the granted rN_ss_tvalid; the granted rN_ss_tready SHALL equal mm_ss_tready; the non-granted tready SHALL be 0.
REQ-011 FEED: SHALL count tvalid&tready beats; on beat pIN_WORDS, SHALL go to DRAIN with the counter cleared.
REQ-012 DRAIN: the granted rN_sm_tvalid SHALL equal mm_sm_tvalid; mm_sm_tready SHALL equal the granted rN_sm_tready; the non-granted sm_tvalid SHALL be 0.
REQ-013 DRAIN: SHALL count beats; on beat pOUT_WORDS, SHALL go to FIN.
REQ-014 SHALL hold mm_ss_tvalid=0 outside FEED and mm_sm_tready=0 outside DRAIN; FEED and DRAIN never overlap.
REQ-015 SHALL latch mm_done at any point after START (sticky done_seen).
REQ-016 FIN: once done_seen=1 (or on the same-cycle mm_done), SHALL pulse req_done[g] for one cycle, clear req_grant and done_seen, and return to IDLE.
REQ-017 A req_start from the active requester during its job SHALL set pending and be served after FIN, subject to round-robin.
REQ-018 The tdata muxes SHALL be combinational from the granted index; there is no added latency on either stream.
REQ-019 Beat counters SHALL be wide enough for max(pIN_WORDS, pOUT_WORDS) and SHALL never wrap within a job.

Reset
REQ-020 On axis_rst_n=0, SHALL asynchronously force IDLE, pending=0, req_grant=0, req_done=0, mm_start=0, counters=0, done_seen=0, last-served=1.
REQ-021 Reset mid-job SHALL abandon the job without a req_done pulse; all stream valid/ready outputs SHALL be 0 during reset.

Structure
REQ-022 Package mm_arb_pkg SHALL hold the FSM state encoding and the default pIN_WORDS/pOUT_WORDS constants.
REQ-023 The round-robin picker SHALL be one sub-module, mm_arb_rr (pending[1:0] and last in; grant one-hot out).

Verification
REQ-024 Single job: pulse req_start[0] with mm_idle=1 -> mm_start is high exactly one cycle; 32 beats reach mm; 16 beats return on r0; mm_done is seen; req_done[0] pulses once.
REQ-025 Contention: req_start=2'b11 in the same cycle -> r0 is served first, then r1; req_grant sequence is 01, 00, 10.
REQ-026 Backpressure: random mm_ss_tready and r1_sm_tready -> exactly 32 and 16 beats with data order preserved; r0 streams stay idle (tready=0, tvalid=0).
REQ-027 Early done: mm_done arrives during DRAIN beat 5 -> FIN still waits for all 16 beats, then req_done pulses.
REQ-028 mm_idle=0 with pending set -> no mm_start until mm_idle rises; the grant follows one cycle later.
REQ-029 Reset asserted at FEED beat 10 -> all outputs return to 0 and the FSM is in IDLE; a new req_start[1] then completes a full job.
